// File: rtl/demux_1x4_tdm.sv
// Time-division 1-to-4 demultiplexer: locks to frame_sync on slot 0 and steers samples to y0..y3.
// Define DEMUX_SYNC_CHECK_EN to flag and resync on a frame_sync seen mid-frame while locked.
module demux_1x4_tdm #(
  parameter int WIDTH  = 1,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [WIDTH-1:0]  y0,
  output logic [WIDTH-1:0]  y1,
  output logic [WIDTH-1:0]  y2,
  output logic [WIDTH-1:0]  y3,
  output logic [3:0]        y_valid,
  output logic [1:0]        cur_sel,
  output logic              locked,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   resync;
  logic   restart;

`ifdef DEMUX_SYNC_CHECK_EN
  assign resync = frame_sync && (cur_sel != 2'd0);
`else
  assign resync = 1'b0;
`endif

  // Both the initial lock and a mid-frame resync restart the frame at slot 0.
  assign restart = (state == HUNT) ? frame_sync : resync;
  assign locked  = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      y0         <= '0;
      y1         <= '0;
      y2         <= '0;
      y3         <= '0;
      y_valid    <= 4'b0000;
      cur_sel    <= 2'd0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      sync_err   <= 1'b0;
    end else begin
      y_valid    <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (din_valid) begin
        if (restart) begin
          y0       <= din;
          y_valid  <= 4'b0001;
          cur_sel  <= 2'd1;
          state    <= LOCKED;
          sync_err <= resync;
        end else if (state == LOCKED) begin
          unique case (cur_sel)
            2'd0:    y0 <= din;
            2'd1:    y1 <= din;
            2'd2:    y2 <= din;
            default: y3 <= din;
          endcase
          y_valid <= 4'b0001 << cur_sel;
          cur_sel <= cur_sel + 2'd1;
          if (cur_sel == 2'd3) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + FCNT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_1x4_tdm.sv
// Directed bench for demux_1x4_tdm: a behavioural model queues expected outputs per driven cycle.
// Build with DEMUX_SYNC_CHECK_EN to match an RTL build with the resync check enabled.
module tb_demux_1x4_tdm;

  localparam int WIDTH  = 4;
  localparam int FCNT_W = 2;
`ifdef DEMUX_SYNC_CHECK_EN
  localparam bit SYNC_CHECK = 1'b1;
`else
  localparam bit SYNC_CHECK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WIDTH-1:0]  din = '0;
  logic              din_valid = 1'b0;
  logic              frame_sync = 1'b0;
  logic [WIDTH-1:0]  y0, y1, y2, y3;
  logic [3:0]        y_valid;
  logic [1:0]        cur_sel;
  logic              locked;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_cnt;
  logic              sync_err;

  demux_1x4_tdm #(.WIDTH(WIDTH), .FCNT_W(FCNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .y_valid    (y_valid),
    .cur_sel    (cur_sel),
    .locked     (locked),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0]  y0, y1, y2, y3;
    logic [3:0]        yv;
    logic [1:0]        sel;
    logic              lk;
    logic              fd;
    logic [FCNT_W-1:0] cnt;
    logic              se;
  } exp_t;

  exp_t sbq[$];

  logic [WIDTH-1:0]  my [4];
  logic [3:0]        myv;
  logic [1:0]        msel;
  logic              mlk, mfd, mse;
  logic [FCNT_W-1:0] mcnt;

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) my[i] = '0;
    myv = 4'b0000; msel = 2'd0; mlk = 1'b0; mfd = 1'b0; mse = 1'b0; mcnt = '0;
  endtask

  task automatic modelStep(input logic v, input logic s, input logic [WIDTH-1:0] d);
    myv = 4'b0000; mfd = 1'b0; mse = 1'b0;
    if (v) begin
      if (!mlk) begin
        if (s) begin
          my[0] = d; myv = 4'b0001; msel = 2'd1; mlk = 1'b1;
        end
      end else if (SYNC_CHECK && s && msel != 2'd0) begin
        mse = 1'b1; my[0] = d; myv = 4'b0001; msel = 2'd1;
      end else begin
        my[msel] = d;
        myv = 4'b0001 << msel;
        if (msel == 2'd3) begin
          mfd = 1'b1;
          mcnt = mcnt + 1'b1;
        end
        msel = msel + 2'd1;
      end
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.y0 = my[0]; e.y1 = my[1]; e.y2 = my[2]; e.y3 = my[3];
    e.yv = myv; e.sel = msel; e.lk = mlk; e.fd = mfd; e.cnt = mcnt; e.se = mse;
    return e;
  endfunction

  task automatic checkOutput(input string step);
    exp_t e;
    checks++;
    assert (sbq.size() != 0) else begin
      failures++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", step);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      cmp({step, "_y0"}, 32'(y0), 32'(e.y0));
      cmp({step, "_y1"}, 32'(y1), 32'(e.y1));
      cmp({step, "_y2"}, 32'(y2), 32'(e.y2));
      cmp({step, "_y3"}, 32'(y3), 32'(e.y3));
      cmp({step, "_y_valid"}, 32'(y_valid), 32'(e.yv));
      cmp({step, "_cur_sel"}, 32'(cur_sel), 32'(e.sel));
      cmp({step, "_locked"}, 32'(locked), 32'(e.lk));
      cmp({step, "_frame_done"}, 32'(frame_done), 32'(e.fd));
      cmp({step, "_frame_cnt"}, 32'(frame_cnt), 32'(e.cnt));
      cmp({step, "_sync_err"}, 32'(sync_err), 32'(e.se));
    end
  endtask

  task automatic applyStimulus(input string step, input logic v, input logic s,
                               input logic [WIDTH-1:0] d);
    din_valid = v; frame_sync = s; din = d;
    modelStep(v, s, d);
    sbq.push_back(snapshot());
    @(posedge clk);
    #1;
    checkOutput(step);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sbq.push_back(snapshot());
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // HUNT: unsynced samples dropped, sync without valid ignored, then lock.
    applyStimulus("hunt_drop0", 1'b1, 1'b0, 4'h5);
    applyStimulus("hunt_drop1", 1'b1, 1'b0, 4'h6);
    applyStimulus("hunt_novalid", 1'b0, 1'b1, 4'h7);
    applyStimulus("hunt_lock", 1'b1, 1'b1, 4'h1);
    applyStimulus("first_s1", 1'b1, 1'b0, 4'h2);
    applyStimulus("first_s2", 1'b1, 1'b0, 4'h3);
    applyStimulus("first_s3", 1'b1, 1'b0, 4'h4);

    applyStimulus("b2b_s0", 1'b1, 1'b1, 4'h1);
    applyStimulus("b2b_s1", 1'b1, 1'b0, 4'h0);
    applyStimulus("b2b_s2", 1'b1, 1'b0, 4'h1);
    applyStimulus("b2b_s3", 1'b1, 1'b0, 4'h1);

    applyStimulus("gap_s0", 1'b1, 1'b1, 4'h9);
    applyStimulus("gap_s1", 1'b1, 1'b0, 4'hA);
    applyStimulus("gap_idle0", 1'b0, 1'b0, 4'hF);
    applyStimulus("gap_idle1", 1'b0, 1'b1, 4'hE);
    applyStimulus("gap_s2", 1'b1, 1'b0, 4'hB);
    applyStimulus("gap_s3", 1'b1, 1'b0, 4'hC);

    applyStimulus("mis_s0", 1'b1, 1'b1, 4'h3);
    applyStimulus("mis_s1", 1'b1, 1'b0, 4'h4);
    applyStimulus("mis_sync", 1'b1, 1'b1, 4'h7);
    applyStimulus("mis_next0", 1'b1, 1'b0, 4'h8);
    applyStimulus("mis_next1", 1'b1, 1'b0, 4'hD);

    // Five more frames with random data and gaps; the 2-bit frame counter wraps.
    for (int f = 0; f < 5; f++) begin
      while (msel != 2'd0)
        applyStimulus("align", 1'b1, 1'b0, 4'($urandom_range(0, 15)));
      applyStimulus("wrap_s0", 1'b1, 1'b1, 4'($urandom_range(0, 15)));
      for (int k = 1; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0)
          applyStimulus("wrap_gap", 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        applyStimulus("wrap_sn", 1'b1, 1'b0, 4'($urandom_range(0, 15)));
      end
    end

    // Mid-frame asynchronous reset takes effect without a clock edge.
    applyStimulus("pre_rst_s0", 1'b1, 1'b1, 4'h6);
    applyStimulus("pre_rst_s1", 1'b1, 1'b0, 4'h5);
    #2;
    rst_n = 1'b0;
    din_valid = 1'b0; frame_sync = 1'b0;
    #1;
    modelReset();
    sbq.push_back(snapshot());
    checkOutput("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst_drop", 1'b1, 1'b0, 4'h5);
    applyStimulus("post_rst_lock", 1'b1, 1'b1, 4'h6);
    applyStimulus("post_rst_s1", 1'b1, 1'b0, 4'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
